// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - single-outstanding DRAM model answering a request FIFO.
// Writes consume one word from the write-data FIFO; reads answer after a fixed latency.
module dram_responder #(
  parameter int LOG_DRAM_SIZE = 6,
  parameter int PAGE_LEN      = 32,
  parameter int LOG_ADDR_SIZE = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
  parameter int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE,
  parameter int READ_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    frq_read_en,
  input  logic [LOG_REQ_SIZE-1:0] frq_read_data,
  input  logic                    frq_empty,
  output logic                    fwd_read_en,
  input  logic [PAGE_LEN-1:0]     fwd_read_data,
  input  logic                    fwd_empty,
  output logic                    frd_write_en,
  output logic [PAGE_LEN-1:0]     frd_write_data,
  input  logic                    frd_full,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic                    uninit_rd,
  output logic                    busy
);

  localparam int DEPTH = 1 << LOG_ADDR_SIZE;

  typedef enum logic [2:0] {IDLE, WDATA, RLAT, RESP, GAP} state_t;

  state_t                   r_state;
  logic [LOG_ADDR_SIZE-1:0] r_addr;
  logic [3:0]               r_lat_cnt;
  logic [DEPTH-1:0]         r_valid;
  logic [PAGE_LEN-1:0]      r_mem [0:DEPTH-1];

  state_t                   w_state_nxt;
  logic [LOG_ADDR_SIZE-1:0] w_addr_nxt;
  logic [3:0]               w_lat_nxt;
  logic [DEPTH-1:0]         w_valid_nxt;
  logic                     w_frq_en_nxt;
  logic                     w_fwd_en_nxt;
  logic                     w_frd_en_nxt;
  logic [PAGE_LEN-1:0]      w_frd_data_nxt;
  logic [15:0]              w_wr_cnt_nxt;
  logic [15:0]              w_rd_cnt_nxt;
  logic                     w_uninit_nxt;
  logic                     w_mem_we;

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_lat_nxt      = r_lat_cnt;
    w_valid_nxt    = r_valid;
    w_frq_en_nxt   = 1'b0;
    w_fwd_en_nxt   = 1'b0;
    w_frd_en_nxt   = 1'b0;
    w_frd_data_nxt = frd_write_data;
    w_wr_cnt_nxt   = wr_count;
    w_rd_cnt_nxt   = rd_count;
    w_uninit_nxt   = uninit_rd;
    w_mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!frq_empty) begin
          w_addr_nxt   = frq_read_data[LOG_REQ_SIZE-1:1];
          w_frq_en_nxt = 1'b1;
          if (frq_read_data[0]) begin
            w_state_nxt = WDATA;
          end else begin
            w_state_nxt = RLAT;
            w_lat_nxt   = 4'(READ_LATENCY - 1);
          end
        end
      end
      WDATA: begin
        if (!fwd_empty) begin
          w_mem_we             = 1'b1;
          w_valid_nxt[r_addr]  = 1'b1;
          w_fwd_en_nxt         = 1'b1;
          w_wr_cnt_nxt         = wr_count + 16'd1;
          w_state_nxt          = GAP;
        end
      end
      RLAT: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_lat_nxt = r_lat_cnt - 4'd1;
        end
      end
      RESP: begin
        // Under back-pressure the last pushed word stays on frd_write_data.
        if (!frd_full) begin
          w_frd_en_nxt = 1'b1;
          w_rd_cnt_nxt = rd_count + 16'd1;
          w_state_nxt  = GAP;
          if (r_valid[r_addr]) begin
            w_frd_data_nxt = r_mem[r_addr];
          end else begin
            w_frd_data_nxt = '0;
            w_uninit_nxt   = 1'b1;
          end
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_lat_cnt      <= 4'd0;
      r_valid        <= '0;
      frq_read_en    <= 1'b0;
      fwd_read_en    <= 1'b0;
      frd_write_en   <= 1'b0;
      frd_write_data <= '0;
      wr_count       <= 16'd0;
      rd_count       <= 16'd0;
      uninit_rd      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr         <= w_addr_nxt;
      r_lat_cnt      <= w_lat_nxt;
      r_valid        <= w_valid_nxt;
      frq_read_en    <= w_frq_en_nxt;
      fwd_read_en    <= w_fwd_en_nxt;
      frd_write_en   <= w_frd_en_nxt;
      frd_write_data <= w_frd_data_nxt;
      wr_count       <= w_wr_cnt_nxt;
      rd_count       <= w_rd_cnt_nxt;
      uninit_rd      <= w_uninit_nxt;
      busy           <= (w_state_nxt != IDLE);
    end
  end

  // Data array has no reset; cleared valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= fwd_read_data;
    end
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 The block SHALL have parameter LOG_DRAM_SIZE, default 6, meaning log2 of DRAM size in bits.
REQ-002 The block SHALL have parameter PAGE_LEN, default 32, meaning the word width in bits.
REQ-003 The block SHALL have parameter LOG_ADDR_SIZE, default LOG_DRAM_SIZE-$clog2(PAGE_LEN), meaning the word address width.
REQ-004 The block SHALL have parameter LOG_REQ_SIZE, default 1+LOG_ADDR_SIZE, meaning the request width, formatted {addr, wr}.
REQ-005 The block SHALL have parameter READ_LATENCY, default 2, legal 1..8, meaning the read latency in cycles.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have ports frq_read_en (output, 1), frq_read_data (input, LOG_REQ_SIZE) and frq_empty (input, 1), forming the request FIFO pop side.
REQ-009 The block SHALL have ports fwd_read_en (output, 1), fwd_read_data (input, PAGE_LEN) and fwd_empty (input, 1), forming the write-data FIFO pop side.
REQ-010 The block SHALL have ports frd_write_en (output, 1), frd_write_data (output, PAGE_LEN) and frd_full (input, 1), forming the read-data FIFO push side.
REQ-011 The block SHALL have port wr_count, output, 16 bits: completed writes.
REQ-012 The block SHALL have port rd_count, output, 16 bits: completed reads.
REQ-013 The block SHALL have port uninit_rd, output, 1 bit: sticky flag, set when an unwritten word is read.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 Input FIFOs SHALL be show-ahead: read_data is valid whenever empty=0, and a one-cycle read_en pops one entry.
REQ-016 All outputs SHALL be registered, and every *_en SHALL be a single-cycle pulse.
REQ-017 Storage SHALL be 2^LOG_ADDR_SIZE words of PAGE_LEN bits, plus one valid bit per word.
REQ-018 The state machine SHALL have states IDLE, WDATA, RLAT, RESP and GAP.
REQ-019 In IDLE with frq_empty=0, the block SHALL latch addr=frq_read_data[LOG_REQ_SIZE-1:1] and wr=frq_read_data[0], and pulse frq_read_en.
REQ-020 On that IDLE transition, the next state SHALL be WDATA if wr=1, else RLAT with lat_cnt=READ_LATENCY-1.
REQ-021 In WDATA with fwd_empty=0, the block SHALL set mem[addr]=fwd_read_data and valid[addr]=1, pulse fwd_read_en, increment wr_count, and go to GAP.
REQ-022 In WDATA with fwd_empty=1, the block SHALL hold state with no pops (indefinite stall).
REQ-023 In RLAT, the block SHALL go to RESP if lat_cnt=0, else decrement lat_cnt.
REQ-024 In RESP with frd_full=0, the block SHALL drive frd_write_data=mem[addr] if valid[addr], else 0, and set uninit_rd.
REQ-025 In that RESP case it SHALL also pulse frd_write_en, increment rd_count, and go to GAP.
REQ-026 In RESP with frd_full=1, the block SHALL hold state with frd_write_en=0 and frd_write_data unchanged.
REQ-027 GAP SHALL deassert all enables and go to IDLE, so FIFO flags settle one cycle before the next sample.
REQ-028 Write latency: fwd_read_en SHALL rise exactly 1 edge after frq_read_en when fwd_empty=0.
REQ-029 Read latency: frd_write_en SHALL rise exactly READ_LATENCY+1 edges after frq_read_en when frd_full=0.
REQ-030 Minimum request spacing SHALL be 3 cycles for a write and READ_LATENCY+3 cycles for a read.
REQ-031 wr_count and rd_count SHALL wrap modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-032 The request address SHALL use all LOG_ADDR_SIZE bits with no range check, and every address SHALL be legal.
REQ-033 Exactly one request SHALL be outstanding at a time, with in-order completion.
REQ-034 A read following a write to the same address SHALL return the new data.

Reset
REQ-035 On rst=1, the block SHALL immediately (asynchronously) set state=IDLE, every *_en=0, frd_write_data=0, wr_count=0, rd_count=0, uninit_rd=0, busy=0 and all valid bits=0.
REQ-036 Reset mid-operation SHALL discard the in-flight request; no pop or push SHALL occur after rst rises.
REQ-037 Memory data contents SHALL NOT be reset; they are unobservable because valid=0.

Verification
REQ-038 The bench SHALL use LOG_DRAM_SIZE=10 and PAGE_LEN=32, giving 5-bit addresses and a 6-bit request.
REQ-039 Scenario 1 (write then read): write addr 3 with data 0xDEADBEEF, then read addr 3 -> exactly one frd_write_en, data 0xDEADBEEF, wr_count=1, rd_count=1, uninit_rd=0.
REQ-040 Scenario 2 (unwritten read): read addr 5 after reset -> frd_write_data=0x00000000 and uninit_rd=1, staying 1 until reset.
REQ-041 Scenario 3 (write-data stall): write request with fwd_empty=1 for 10 cycles -> busy=1, no fwd_read_en, no further frq_read_en; when data arrives, fwd_read_en fires on the next edge and wr_count=1.
REQ-042 Scenario 4 (back-pressure and latency): read with frd_full=1 for 8 cycles -> frd_write_en=0 throughout, then one pulse after release; with READ_LATENCY=4 and frd_full=0, frd_write_en rises exactly 5 edges after frq_read_en.
REQ-043 Scenario 5 (full sweep): write all 32 addresses with data=addr, then read all 32 -> data matches each address, wr_count=32, rd_count=32.
REQ-044 Scenario 6 (reset mid-read): assert rst during RLAT -> no frd_write_en, all counters 0; a subsequent read of the same address returns 0 and sets uninit_rd=1.
